// File: rtl/wb_arbiter_pkg.sv
// Shared regfile write-port definitions: bus widths, the no-op register
// address, write-enable level, zero data word and the write payload type.
package wb_arbiter_pkg;

    localparam int unsigned RegAddrW = 5;
    localparam int unsigned DataW    = 32;

    localparam logic [RegAddrW-1:0] NOPRegAddr  = '0;
    localparam logic                WriteEnable = 1'b1;
    localparam logic [DataW-1:0]    ZeroWord    = '0;

    // One regfile write: destination register and data.
    typedef struct packed {
        logic [RegAddrW-1:0] addr;
        logic [DataW-1:0]    data;
    } wr_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Buffer of pending secondary regfile writes.
// Each entry holds a valid bit plus address/data. Entries whose address
// matches inval_addr (when inval_en) are treated as invalid this cycle and
// cleared at the clock edge. hit1/hit2 report a valid entry matching a
// non-zero read address, using the post-invalidation view.
// Ports: clk, rst (sync, active-low), push/push_req, pop, inval_en/inval_addr,
//        raddr1/raddr2, head_valid/head_req, empty, full, hit1/hit2.
// The caller guarantees push only when !full and pop only when !empty.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  wr_req_t             push_req,
    input  logic                pop,
    input  logic                inval_en,
    input  logic [RegAddrW-1:0] inval_addr,
    input  logic [RegAddrW-1:0] raddr1,
    input  logic [RegAddrW-1:0] raddr2,
    output logic                head_valid,
    output wr_req_t             head_req,
    output logic                empty,
    output logic                full,
    output logic                hit1,
    output logic                hit2
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_eff;
    wr_req_t          mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Same-cycle invalidation view and read-address matching.
    always_comb begin
        valid_eff = '0;
        hit1      = 1'b0;
        hit2      = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            valid_eff[i] = valid_q[i] && !(inval_en && (mem_q[i].addr == inval_addr));
            if (valid_eff[i] && (raddr1 != NOPRegAddr) && (mem_q[i].addr == raddr1)) begin
                hit1 = 1'b1;
            end
            if (valid_eff[i] && (raddr2 != NOPRegAddr) && (mem_q[i].addr == raddr2)) begin
                hit2 = 1'b1;
            end
        end
    end

    assign head_valid = valid_eff[rd_ptr_q];
    assign head_req   = mem_q[rd_ptr_q];
    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(DEPTH));

    // Pointers, occupancy and valid bits; power-of-two depth wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q <= valid_eff;
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: the pipeline write-back (primary) always wins
// the single port combinationally; secondary (multi-cycle unit) writes are
// buffered in wb_fifo and drained in idle cycles. A primary write invalidates
// older buffered writes to the same register.
// Ports: clk, rst (sync, active-low); pipe_we/pipe_waddr/pipe_wdata (primary);
//        sec_valid/sec_waddr/sec_wdata/sec_ready (secondary handshake);
//        we/waddr/wdata (regfile port); raddr1/raddr2 -> pend_hit1/pend_hit2
//        (read hits a pending buffered write); stall_req (drain request).
// Optional: define WB_ARB_STARVE_EN to enable the starvation counter that
// raises stall_req; otherwise stall_req is tied low.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pipe_we,
    input  logic [RegAddrW-1:0] pipe_waddr,
    input  logic [DataW-1:0]    pipe_wdata,
    input  logic                sec_valid,
    input  logic [RegAddrW-1:0] sec_waddr,
    input  logic [DataW-1:0]    sec_wdata,
    output logic                sec_ready,
    output logic                we,
    output logic [RegAddrW-1:0] waddr,
    output logic [DataW-1:0]    wdata,
    input  logic [RegAddrW-1:0] raddr1,
    input  logic [RegAddrW-1:0] raddr2,
    output logic                pend_hit1,
    output logic                pend_hit2,
    output logic                stall_req
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("wb_arbiter: FIFO_DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic    prim_issue;
    logic    push;
    logic    pop;
    logic    head_issue;
    logic    head_valid;
    wr_req_t head_req;
    logic    fifo_empty;
    logic    fifo_full;
    logic    hit1;
    logic    hit2;

    assign prim_issue = rst && pipe_we && (pipe_waddr != NOPRegAddr);
    // Readiness uses registered occupancy only; a same-cycle pop does not help.
    assign sec_ready  = rst && !fifo_full;
    // Writes to r0 complete the handshake but are never stored.
    assign push       = sec_valid && sec_ready && (sec_waddr != NOPRegAddr);
    // Invalid heads are discarded even while the primary owns the port.
    assign pop        = rst && !fifo_empty && (!head_valid || !prim_issue);
    assign head_issue = pop && head_valid;

    assign pend_hit1  = rst && hit1;
    assign pend_hit2  = rst && hit2;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_req   ('{addr: sec_waddr, data: sec_wdata}),
        .pop        (pop),
        .inval_en   (prim_issue),
        .inval_addr (pipe_waddr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .head_valid (head_valid),
        .head_req   (head_req),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .hit1       (hit1),
        .hit2       (hit2)
    );

    // Port mux: primary first, then a valid buffered head.
    always_comb begin
        we    = 1'b0;
        waddr = NOPRegAddr;
        wdata = ZeroWord;
        if (prim_issue) begin
            we    = WriteEnable;
            waddr = pipe_waddr;
            wdata = pipe_wdata;
        end else if (head_issue) begin
            we    = WriteEnable;
            waddr = head_req.addr;
            wdata = head_req.data;
        end
    end

`ifdef WB_ARB_STARVE_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_q;
    logic [StarveW-1:0] starve_d;
    logic               stall_q;

    // Count cycles a valid head loses to the primary; any pop or empty FIFO restarts it.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (head_valid && prim_issue && (starve_q < StarveW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StarveW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= (starve_d == StarveW'(STARVE_LIMIT));
        end
    end

    assign stall_req = stall_q;
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a per-cycle vector table plus
// hand-written reset and starvation sequences. Expected regfile writes are
// queued when stimulus is driven and popped by a monitor whenever we=1.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

`ifdef WB_ARB_STARVE_EN
    localparam logic StarveOn = 1'b1;
`else
    localparam logic StarveOn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        sec_valid;
    logic [4:0]  sec_waddr;
    logic [31:0] sec_wdata;
    logic        sec_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        pend_hit1;
    logic        pend_hit2;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .sec_valid  (sec_valid),
        .sec_waddr  (sec_waddr),
        .sec_wdata  (sec_wdata),
        .sec_ready  (sec_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .pend_hit1  (pend_hit1),
        .pend_hit2  (pend_hit2),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every issued write must be the next expected one; idle port must be all zero.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(waddr), 32'(mon_e[36:32]));
                chk("wr_data", wdata, mon_e[31:0]);
            end
        end else begin
            chk("idle_we", 32'(we), 32'h0);
            chk("idle_waddr", 32'(waddr), 32'h0);
            chk("idle_wdata", wdata, 32'h0);
        end
    end

    task automatic step(input logic r, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                        input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        rst        = r;
        pipe_we    = pwe;
        pipe_waddr = pa;
        pipe_wdata = pd;
        sec_valid  = sv;
        sec_waddr  = sa;
        sec_wdata  = sd;
        raddr1     = r1;
        raddr2     = r2;
        @(negedge clk);
    endtask

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  sa;
        logic [31:0] sd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        erdy;
        logic        eh1;
        logic        eh2;
    } vec_t;

    function automatic vec_t mk(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                                input logic erdy, input logic eh1, input logic eh2);
        vec_t v;
        v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.sv = sv; v.sa = sa; v.sd = sd;
        v.r1 = r1; v.r2 = r2;
        v.ewe = ewe; v.ea = ea; v.ed = ed;
        v.erdy = erdy; v.eh1 = eh1; v.eh2 = eh2;
        return v;
    endfunction

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        // Primary only, idle-port drain, pending hit before pop.
        vecs[0]  = mk(1'b1, 5'd5, 32'h11,  1'b0, 5'd0, 32'h0,  5'd5, 5'd0,  1'b1, 5'd5, 32'h11,  1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd7, 32'hAA, 5'd7, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd7, 5'd0,  1'b1, 5'd7, 32'hAA,  1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd7, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        // Fill while primary busy; third request refused; in-order drain.
        vecs[4]  = mk(1'b1, 5'd1, 32'h100, 1'b1, 5'd8, 32'hB1, 5'd0, 5'd0,  1'b1, 5'd1, 32'h100, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 5'd2, 32'h200, 1'b1, 5'd9, 32'hB2, 5'd8, 5'd9,  1'b1, 5'd2, 32'h200, 1'b1, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 5'd3, 32'h300, 1'b1, 5'd10,32'hB3, 5'd9, 5'd10, 1'b1, 5'd3, 32'h300, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd8, 5'd0,  1'b1, 5'd8, 32'hB1,  1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd8, 5'd9,  1'b1, 5'd9, 32'hB2,  1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd9, 5'd10, 1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        // Younger primary write invalidates the buffered one.
        vecs[10] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 32'h1,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 5'd3, 32'h2,   1'b0, 5'd0, 32'h0,  5'd3, 5'd0,  1'b1, 5'd3, 32'h2,   1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd3, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        // r0 writes: secondary dropped, primary not issued.
        vecs[13] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd0, 32'hDEAD,5'd0,5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 5'd0, 32'h55,  1'b0, 5'd0, 32'h0,  5'd0, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        // Simultaneous push and pop keeps occupancy at one.
        vecs[16] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd4, 32'h44, 5'd4, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 5'd0, 32'h0,   1'b1, 5'd6, 32'h66, 5'd6, 5'd4,  1'b1, 5'd4, 32'h44,  1'b1, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd6, 5'd4,  1'b1, 5'd6, 32'h66,  1'b1, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,  5'd6, 5'd0,  1'b0, 5'd0, 32'h0,   1'b1, 1'b0, 1'b0);

        rst = 1'b0; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        sec_valid = 1'b0; sec_waddr = '0; sec_wdata = '0; raddr1 = '0; raddr2 = '0;

        // Initial reset, with primary write requested (must be ignored).
        step(1'b0, 1'b1, 5'd5, 32'h77, 1'b1, 5'd6, 32'h88, 5'd6, 5'd5);
        step(1'b0, 1'b1, 5'd5, 32'h77, 1'b1, 5'd6, 32'h88, 5'd6, 5'd5);
        chk("rst_sec_ready", 32'(sec_ready), 32'h0);
        chk("rst_hit1", 32'(pend_hit1), 32'h0);
        chk("rst_stall", 32'(stall_req), 32'h0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].ewe) exp_q.push_back({vecs[i].ea, vecs[i].ed});
            step(1'b1, vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].sv, vecs[i].sa, vecs[i].sd,
                 vecs[i].r1, vecs[i].r2);
            chk($sformatf("v%0d_sec_ready", i), 32'(sec_ready), 32'(vecs[i].erdy));
            chk($sformatf("v%0d_hit1", i), 32'(pend_hit1), 32'(vecs[i].eh1));
            chk($sformatf("v%0d_hit2", i), 32'(pend_hit2), 32'(vecs[i].eh2));
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'h0);
        end

        // Reset mid-operation discards two buffered writes.
        exp_q.push_back({5'd1, 32'h1001});
        step(1'b1, 1'b1, 5'd1, 32'h1001, 1'b1, 5'd11, 32'hD1, 5'd11, 5'd12);
        chk("mr_rdy0", 32'(sec_ready), 32'h1);
        exp_q.push_back({5'd2, 32'h1002});
        step(1'b1, 1'b1, 5'd2, 32'h1002, 1'b1, 5'd12, 32'hD2, 5'd11, 5'd12);
        chk("mr_hit1_pre", 32'(pend_hit1), 32'h1);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd14, 32'hD4, 5'd11, 5'd12);
        chk("mr_rdy_in_rst", 32'(sec_ready), 32'h0);
        chk("mr_hit1_in_rst", 32'(pend_hit1), 32'h0);
        chk("mr_hit2_in_rst", 32'(pend_hit2), 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
        chk("mr_rdy_after", 32'(sec_ready), 32'h1);
        chk("mr_hit1_after", 32'(pend_hit1), 32'h0);
        chk("mr_hit2_after", 32'(pend_hit2), 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd14, 5'd0);
        chk("mr_hit14", 32'(pend_hit1), 32'h0);

        // Starvation: primary every cycle keeps a valid head blocked.
        exp_q.push_back({5'd1, 32'h2001});
        step(1'b1, 1'b1, 5'd1, 32'h2001, 1'b1, 5'd13, 32'hC, 5'd13, 5'd0);
        chk("st_stall_0", 32'(stall_req), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({5'd2, 32'h3000 + 32'(k)});
            step(1'b1, 1'b1, 5'd2, 32'h3000 + 32'(k), 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
            chk($sformatf("st_stall_%0d", k), 32'(stall_req), 32'h0);
            chk($sformatf("st_hit_%0d", k), 32'(pend_hit1), 32'h1);
        end
        exp_q.push_back({5'd2, 32'h3005});
        step(1'b1, 1'b1, 5'd2, 32'h3005, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
        chk("st_stall_5", 32'(stall_req), 32'(StarveOn));
        exp_q.push_back({5'd13, 32'hC});
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
        chk("st_stall_issue", 32'(stall_req), 32'(StarveOn));
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd0);
        chk("st_stall_clear", 32'(stall_req), 32'h0);
        chk("st_hit_clear", 32'(pend_hit1), 32'h0);

        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of buffered secondary writes (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive blocked cycles before stall request.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 pipe_we / pipe_waddr / pipe_wdata  in  1/5/32  primary (pipeline WB) write, no backpressure.
REQ-006 sec_valid / sec_waddr / sec_wdata  in  1/5/32  secondary (multi-cycle unit) write request.
REQ-007 sec_ready  out  1  secondary request accepted this cycle when sec_valid && sec_ready.
REQ-008 we / waddr / wdata  out  1/5/32  single regfile write port.
REQ-009 raddr1 / raddr2  in  5/5  ID-stage read addresses.
REQ-010 pend_hit1 / pend_hit2  out  1/1  read address matches a valid buffered write.
REQ-011 stall_req  out  1  request pipeline stall to drain buffer.

Function
REQ-012 Primary write SHALL be issued the same cycle (combinational), when pipe_we=1 and pipe_waddr!=0, and SHALL always win the port.
REQ-013 Buffered head SHALL be issued only in cycles without a primary issue; issue pops it; earliest issue is the cycle after acceptance.
REQ-014 sec_ready SHALL equal "FIFO not full" from registered occupancy; a pop in the same cycle does not make a full FIFO ready.
REQ-015 Accepted request with sec_waddr=0 SHALL be dropped (handshake completes, nothing enqueued).
REQ-016 On primary issue to address A, every valid buffered entry with address A SHALL be invalidated (younger write wins).
REQ-017 An invalid head SHALL be popped without asserting we, in any cycle, including primary-issue cycles.
REQ-018 we=0, waddr=0, wdata=0 when nothing issues.
REQ-019 pend_hitN=1 iff raddrN!=0 and a valid buffered entry (after this cycle's invalidation) has address raddrN; combinational.
REQ-020 Simultaneous enqueue and pop SHALL keep occupancy; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-021 rst=0 at posedge: FIFO empty, all entries invalid, pointers 0, starve counter 0, stall_req 0.
REQ-022 While rst=0: we=0, sec_ready=0, pend_hit1/2=0; pipe inputs ignored.
REQ-023 Reset mid-operation SHALL discard buffered writes without issuing them.

Configuration
REQ-024 Macro WB_ARB_STARVE_EN defined: counter increments each cycle a valid head is blocked by a primary issue, saturates at STARVE_LIMIT; stall_req registered =1 when counter reaches STARVE_LIMIT; counter and stall_req clear the cycle after head issue or FIFO becoming empty.
REQ-025 Macro undefined: no counter, stall_req tied 0, pure fixed priority.

Structure
REQ-026 Bus widths, NOPRegAddr, WriteEnable, ZeroWord SHALL come from the shared defines include; no local redefinition.
REQ-027 Buffer SHALL be sub-module wb_fifo (valid bit, address, data per entry, per-entry address-match invalidate port, match outputs for two read addresses).

Verification
REQ-028 Primary only: pipe_we=1, waddr=5, wdata=0x11 -> we=1, waddr=5, wdata=0x11 same cycle; sec_ready=1.
REQ-029 Idle port: sec write (7,0xAA) accepted cycle N -> we=1, waddr=7, wdata=0xAA cycle N+1; pend_hit1=1 for raddr1=7 in cycle N+1 only before pop.
REQ-030 Full: three back-to-back sec writes with primary busy -> third sees sec_ready=0; drains in order once primary idles.
REQ-031 Invalidation: buffer (3,0x1), then primary (3,0x2) -> regfile receives only 0x2; entry popped with we=0; pend_hit for 3 drops.
REQ-032 Starvation (WB_ARB_STARVE_EN): buffered entry, primary writes every cycle -> stall_req=1 after 4 blocked cycles; clears the cycle after head issues; macro off -> stall_req stays 0.
REQ-033 Reset: two entries buffered, rst=0 one cycle -> no write issued, sec_ready=0 during reset, =1 after, pend_hit=0.
